// File: rtl/aes_ctr_sequencer_pkg.sv
// Shared types and constants for the AES-CTR sequencer slice.
package aes_ctr_pkg;

  localparam int unsigned BLK_W      = 128;
  localparam int unsigned CTR_W_DEF  = 32;
  localparam int unsigned NBLK_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_XFER,
    ST_DRAIN,
    ST_ABORT
  } ctr_state_e;

endpackage

// File: rtl/aes_ctr_sequencer_if.sv
// Data stream and encipher-engine handshake bundle of the CTR sequencer.
interface aes_ctr_sequencer_if;

  logic                          din_valid;
  logic                          din_ready;
  logic [aes_ctr_pkg::BLK_W-1:0] din;
  logic                          dout_valid;
  logic                          dout_ready;
  logic [aes_ctr_pkg::BLK_W-1:0] dout;
  logic                          eng_next;
  logic [aes_ctr_pkg::BLK_W-1:0] eng_block;
  logic                          eng_ready;
  logic [aes_ctr_pkg::BLK_W-1:0] eng_result;

  modport master (
    input  din_valid, din, dout_ready, eng_ready, eng_result,
    output din_ready, dout_valid, dout, eng_next, eng_block
  );

  modport slave (
    output din_valid, din, dout_ready, eng_ready, eng_result,
    input  din_ready, dout_valid, dout, eng_next, eng_block
  );

endinterface

// File: rtl/aes_ctr_sequencer.sv
// AES counter-mode sequencer: feeds counter blocks to a shared encipher
// engine and XORs each keystream block with the streamed input data.
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int unsigned CTR_W  = CTR_W_DEF,
  parameter int unsigned NBLK_W = NBLK_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [BLK_W-1:0]  cfg_iv,
  input  logic [NBLK_W-1:0] cfg_nblocks,
  output logic              busy,
  output logic              done,
  aes_ctr_sequencer_if.master bus
);

  // Shifting by the full block width yields 0, so CTR_W==128 gives all ones.
  localparam logic [BLK_W-1:0] CTR_MASK = (BLK_W'(1) << CTR_W) - BLK_W'(1);

  function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] c);
    return (c & ~CTR_MASK) | ((c + BLK_W'(1)) & CTR_MASK);
  endfunction

  ctr_state_e        state, state_n;
  logic [BLK_W-1:0]  ctr_reg;
  logic [NBLK_W-1:0] left_reg;
  logic [BLK_W-1:0]  ks_reg;
  logic              ks_valid;
  logic [BLK_W-1:0]  dout_reg;
  logic              dout_valid;

  logic din_ready, eng_next;
  logic accept, capture, xfer_hs, finish, kill;

  assign bus.din_ready  = din_ready;
  assign bus.eng_next   = eng_next;
  assign bus.eng_block  = ctr_reg;
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid;

  always_comb begin
    state_n   = state;
    eng_next  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    xfer_hs   = 1'b0;
    finish    = 1'b0;
    kill      = 1'b0;
    din_ready = (state == ST_XFER) && ks_valid && (!dout_valid || bus.dout_ready);

    if ((state != ST_IDLE) && abort) begin
      // An in-flight engine operation must be drained before returning to IDLE.
      kill    = 1'b1;
      state_n = ((state == ST_WAIT) || !bus.eng_ready) ? ST_ABORT : ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            accept  = 1'b1;
            state_n = (cfg_nblocks == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.eng_ready) begin
            eng_next = 1'b1;
            state_n  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.eng_ready) begin
            capture = 1'b1;
            state_n = ST_XFER;
          end
        end
        ST_XFER: begin
          if (din_ready && bus.din_valid) begin
            xfer_hs = 1'b1;
            state_n = (left_reg == NBLK_W'(1)) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (!dout_valid || bus.dout_ready) begin
            finish  = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_ABORT: begin
          if (bus.eng_ready) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_reg    <= '0;
      left_reg   <= '0;
      ks_reg     <= '0;
      ks_valid   <= 1'b0;
      dout_reg   <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_n != ST_IDLE);
      done <= finish;
      if (bus.dout_ready) dout_valid <= 1'b0;
      if (accept) begin
        ctr_reg  <= cfg_iv;
        left_reg <= cfg_nblocks;
      end
      if (capture) begin
        ks_reg   <= bus.eng_result;
        ks_valid <= 1'b1;
        ctr_reg  <= ctr_inc(ctr_reg);
      end
      if (xfer_hs) begin
        dout_reg   <= bus.din ^ ks_reg;
        dout_valid <= 1'b1;
        ks_valid   <= 1'b0;
        left_reg   <= left_reg - NBLK_W'(1);
      end
      if (kill) begin
        dout_valid <= 1'b0;
        ks_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/aes_ctr_sequencer.md
Name: aes_ctr_sequencer

Overview:
- Runs AES counter mode (CTR) for a fixed block count, using one shared AES encipher engine.
- The engine has a next/ready handshake, 128-bit block in and result out. This block supplies the counter blocks, pulses `eng_next`, and XORs each keystream block with streamed input data.
- It sits between the core register/control layer and the encipher engine. The key and key length are configured elsewhere.

Parameters:
- CTR_W, 32, width of the incremented low counter field (1..128); bits above it never change.
- NBLK_W, 16, width of the block-count field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts an operation (ignored unless busy=0)
- abort  in  1  synchronous abort of the current operation
- cfg_iv  in  128  initial counter block, sampled on accepted start
- cfg_nblocks  in  NBLK_W  number of blocks, sampled on accepted start
- busy  out  1  high from the accepted start until return to IDLE
- done  out  1  one-cycle pulse when the last output block is consumed
- din_valid  in  1  input data block valid
- din_ready  out  1  input data block accepted when din_valid and din_ready are both high
- din  in  128  plaintext/ciphertext block
- dout_valid  out  1  output block valid
- dout_ready  in  1  output block consumed
- dout  out  128  din XOR keystream
- eng_next  out  1  one-cycle start pulse to the engine
- eng_block  out  128  counter block presented to the engine
- eng_ready  in  1  engine idle / result valid (1 after engine reset, 0 the cycle after eng_next)
- eng_result  in  128  keystream block, valid while eng_ready=1 after an operation

Behaviour:
- Reset values:
  - Outputs: busy=0, done=0, din_ready=0, dout_valid=0, eng_next=0, dout=0, eng_block=0.
  - State: IDLE. Internal counter and blocks_left are 0.
- Registers:
  - ctr_reg (128)
  - left_reg (NBLK_W)
  - ks_reg (128), plus a ks_valid flag
  - dout_reg with dout_valid
- eng_block = ctr_reg at all times.
- States:
  - IDLE:
    - start & !abort: load ctr_reg=cfg_iv, left_reg=cfg_nblocks, busy<=1.
    - If cfg_nblocks==0, go to DRAIN; done pulses the next cycle and the engine is never touched.
    - Otherwise go to ISSUE.
  - ISSUE: wait for eng_ready=1, then assert eng_next for exactly one cycle and go to WAIT.
  - WAIT: on eng_ready=1, capture ks_reg=eng_result, set ks_valid=1, increment ctr_reg, go to XFER.
    - Counter increment: ctr_reg[CTR_W-1:0]+1 modulo 2^CTR_W. All-ones wraps to 0; upper bits are unchanged.
  - XFER:
    - din_ready = ks_valid & (!dout_valid | dout_ready).
    - On din handshake: dout_reg<=din^ks_reg, dout_valid<=1, ks_valid<=0, left_reg-=1.
    - If left_reg was 1, go to DRAIN; otherwise go to ISSUE.
    - The next keystream computes while dout waits.
  - DRAIN: wait for !dout_valid, or dout_valid & dout_ready. Then pulse done, busy<=0, go to IDLE.
- dout_valid rules:
  - dout_valid is cleared by dout_ready in any state.
  - dout is held stable while dout_valid & !dout_ready.
- din_ready is 0 in every state except XFER.
- Simultaneous output and input: dout_ready and a din handshake in the same cycle give back-to-back throughput with no bubble.
- abort (any non-IDLE state, priority over every other event):
  - Clears dout_valid and ks_valid; no done pulse.
  - If the engine is running (state WAIT, or eng_ready=0), go to ABORT. ABORT waits for eng_ready=1, discards the result, then goes to IDLE.
  - Otherwise go straight to IDLE.
  - busy stays 1 until IDLE is reached.
- start while busy=1 is ignored. abort in IDLE has no effect.
- reset mid-operation returns to reset values next cycle. The engine is reset by the same reset.
- Latency:
  - Accepted start at cycle 0 gives eng_next at cycle 1 if eng_ready=1.
  - The first din_ready arrives in the cycle after eng_ready rises.

Decomposition:
- Shared package aes_ctr_pkg holds:
  - The state enum (IDLE, ISSUE, WAIT, XFER, DRAIN, ABORT), 3 bits.
  - The AES block width constant 128.
  - The default CTR_W/NBLK_W constants.
- Single module, no sub-module.
- The counter incrementer is a local function.

Test Plan:
- SP800-38A F.5.1 single block.
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, AES-128; cfg_iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; nblocks=1; din 6bc1bee22e409f96e93d7e117393172a.
  - Response: dout 874d6191b620e3261bef6864990db6ce, one done pulse, busy falls after consumption.
- Four-block stream, same vector.
  - Stimulus: F.5.1 blocks 2-4 of din.
  - Response: dout 9806f66b7970fdff8617187bb9fffdff, 5ae4df3edbd5d35e5b4f09020db03eab, 1e031dda2fbe03d1792170a0f3009cee.
  - Response: eng_block low word increments fcfdfeff→fcfdff00→fcfdff01→fcfdff02, exactly four eng_next pulses.
- Counter wrap.
  - Stimulus: cfg_iv 00112233445566778899aabbffffffff, nblocks=2.
  - Response: second eng_block = 00112233445566778899aabb00000000.
- Backpressure.
  - Stimulus: dout_ready=0 for 50 cycles with nblocks=3.
  - Response: dout stable, din_ready=0 while the output is full, no block lost or duplicated, done only after the last dout_ready.
- Zero blocks.
  - Stimulus: start with nblocks=0.
  - Response: eng_next never asserted, done at cycle 2, busy high only for cycle 1.
- Abort and restart.
  - Stimulus: abort in WAIT, then start issued immediately.
  - Response: start is ignored until eng_ready=1; no done pulse, dout_valid=0; a new start then completes the F.5.1 block 1 correctly.
